// File: rtl/sseg_mux_driver.sv
// Time-multiplexed N-digit seven-segment driver with per-frame snapshot,
// leading-zero blanking, optional hex glyphs and selectable pin polarity.
module sseg_mux_driver #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int HEX_EN      = 0,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  blank_lz,
  output logic [N_DIGITS-1:0]   an,
  output logic [7:0]            sseg,
  output logic                  frame_tick
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);
  localparam logic INV = (ACTIVE_LOW != 0);
  localparam logic [N_DIGITS-1:0] AN_OFF = {N_DIGITS{INV}};
  localparam logic [7:0] SSEG_OFF = {8{INV}};

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [4*N_DIGITS-1:0] snap_digits;
  logic [N_DIGITS-1:0]   snap_dp;

  logic [N_DIGITS-1:0] lead_zero;
  logic [3:0]          code;
  logic [7:0]          glyph;
  logic [7:0]          seg_on;
  logic [N_DIGITS-1:0] an_on;
  logic                blank;

  // lead_zero[i] is set when snapshot digits N-1 down to i are all zero
  always_comb begin : lz_scan
    logic zero_run;
    zero_run  = 1'b1;
    lead_zero = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run & (snap_digits[4*i +: 4] == 4'd0);
      lead_zero[i] = zero_run;
    end
  end

  always_comb begin
    code  = snap_digits[{idx, 2'b00} +: 4];
    glyph = 8'h00;
    case (code)
      4'h0: glyph = 8'hFC;
      4'h1: glyph = 8'h60;
      4'h2: glyph = 8'hDA;
      4'h3: glyph = 8'hF2;
      4'h4: glyph = 8'h66;
      4'h5: glyph = 8'hB6;
      4'h6: glyph = 8'hBE;
      4'h7: glyph = 8'hE0;
      4'h8: glyph = 8'hFE;
      4'h9: glyph = 8'hE6;
      4'hA: glyph = (HEX_EN != 0) ? 8'hEE : 8'h00;
      4'hB: glyph = (HEX_EN != 0) ? 8'h3E : 8'h00;
      4'hC: glyph = (HEX_EN != 0) ? 8'h9C : 8'h00;
      4'hD: glyph = (HEX_EN != 0) ? 8'h7A : 8'h00;
      4'hE: glyph = (HEX_EN != 0) ? 8'h9E : 8'h00;
      4'hF: glyph = (HEX_EN != 0) ? 8'h8E : 8'h00;
      default: glyph = 8'h00;
    endcase
    // Digit 0 always shows, and a blanked digit keeps its decimal point
    blank     = blank_lz && (idx != '0) && lead_zero[idx];
    seg_on    = blank ? 8'h00 : glyph;
    seg_on[0] = snap_dp[idx];
    an_on     = N_DIGITS'(1) << idx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      idx         <= '0;
      snap_digits <= '0;
      snap_dp     <= '0;
      frame_tick  <= 1'b0;
      an          <= AN_OFF;
      sseg        <= SSEG_OFF;
    end else if (en) begin
      frame_tick <= 1'b0;
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        // Snapshot only at the frame wrap so a frame never mixes old and new data
        if (idx == IDX_MAX) begin
          idx         <= '0;
          snap_digits <= digits;
          snap_dp     <= dp_in;
          frame_tick  <= 1'b1;
        end else begin
          idx <= idx + IW'(1);
        end
      end else begin
        cnt <= cnt + CW'(1);
      end
      an   <= an_on ^ AN_OFF;
      sseg <= seg_on ^ SSEG_OFF;
    end else begin
      frame_tick <= 1'b0;
      an         <= AN_OFF;
      sseg       <= SSEG_OFF;
    end
  end

endmodule

// File: tb/tb_sseg_mux_driver.sv
// Directed bench for sseg_mux_driver: 4 digits, 4-cycle dwell, active-low pins,
// with a hex-enabled twin instance sharing the same stimulus.
module tb_sseg_mux_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  an, an_hex;
  logic [7:0]  sseg, sseg_hex;
  logic        frame_tick, frame_tick_hex;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sseg_mux_driver #(.N_DIGITS(4), .REFRESH_DIV(4), .HEX_EN(0), .ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .en(en), .digits(digits), .dp_in(dp_in),
    .blank_lz(blank_lz), .an(an), .sseg(sseg), .frame_tick(frame_tick)
  );

  sseg_mux_driver #(.N_DIGITS(4), .REFRESH_DIV(4), .HEX_EN(1), .ACTIVE_LOW(1)) dut_hex (
    .clk(clk), .reset(reset), .en(en), .digits(digits), .dp_in(dp_in),
    .blank_lz(blank_lz), .an(an_hex), .sseg(sseg_hex), .frame_tick(frame_tick_hex)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dp, input logic blz);
    digits   = d;
    dp_in    = dp;
    blank_lz = blz;
  endtask

  task automatic waitFrameTick(input string tag);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      tick();
      if (frame_tick === 1'b1) seen = 1'b1;
    end
    checkOutput({tag, " ftick seen"}, {31'b0, seen}, 32'd1);
  endtask

  // Starts just after a frame_tick edge; walks the four digits of one frame
  task automatic readFrame(input string tag, input logic [31:0] exp_seg, input logic [31:0] exp_hex,
                           input logic do_change, input logic [15:0] new_digits);
    logic [3:0] exp_an;
    for (int d = 0; d < 4; d++) begin
      tick();
      exp_an = ~(4'b0001 << d);
      checkOutput($sformatf("%s an d%0d", tag, d), {28'b0, an}, {28'b0, exp_an});
      checkOutput($sformatf("%s an_hex d%0d", tag, d), {28'b0, an_hex}, {28'b0, exp_an});
      checkOutput($sformatf("%s sseg d%0d", tag, d), {24'b0, sseg}, {24'b0, exp_seg[8*d +: 8]});
      checkOutput($sformatf("%s sseg_hex d%0d", tag, d), {24'b0, sseg_hex}, {24'b0, exp_hex[8*d +: 8]});
      if (d == 0) checkOutput({tag, " ftick low"}, {31'b0, frame_tick}, 32'd0);
      if (do_change && d == 1) digits = new_digits;
      repeat (3) tick();
      checkOutput($sformatf("%s an dwell d%0d", tag, d), {28'b0, an}, {28'b0, exp_an});
    end
    checkOutput({tag, " ftick end"}, {31'b0, frame_tick}, 32'd1);
    checkOutput({tag, " ftick_hex end"}, {31'b0, frame_tick_hex}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    applyStimulus(16'h0000, 4'b0000, 1'b0);
    repeat (3) tick();
    checkOutput("t1 reset an", {28'b0, an}, 32'hF);
    checkOutput("t1 reset sseg", {24'b0, sseg}, 32'hFF);
    checkOutput("t1 reset ftick", {31'b0, frame_tick}, 32'd0);
    reset = 1'b0;
    repeat (3) tick();
    checkOutput("t1 hold an", {28'b0, an}, 32'hF);
    checkOutput("t1 hold sseg", {24'b0, sseg}, 32'hFF);
    checkOutput("t1 hold ftick", {31'b0, frame_tick}, 32'd0);

    en = 1'b1;
    applyStimulus(16'h1234, 4'b0000, 1'b0);
    waitFrameTick("t2");
    readFrame("t2", 32'h9F250D99, 32'h9F250D99, 1'b0, 16'h0);

    readFrame("t3 old", 32'h9F250D99, 32'h9F250D99, 1'b1, 16'h5678);
    readFrame("t3 new", 32'h49411F01, 32'h49411F01, 1'b0, 16'h0);

    applyStimulus(16'h0050, 4'b0100, 1'b1);
    waitFrameTick("t4");
    readFrame("t4 0050", 32'hFFFE4903, 32'hFFFE4903, 1'b0, 16'h0);
    applyStimulus(16'h0000, 4'b0000, 1'b1);
    waitFrameTick("t4z");
    readFrame("t4 0000", 32'hFFFFFF03, 32'hFFFFFF03, 1'b0, 16'h0);

    applyStimulus(16'h00AF, 4'b0000, 1'b0);
    waitFrameTick("t5");
    readFrame("t5 00AF", 32'h0303FFFF, 32'h03031171, 1'b0, 16'h0);

    repeat (9) tick();
    checkOutput("t6 pre-reset an", {28'b0, an}, 32'hB);
    reset    = 1'b1;
    blank_lz = 1'b1;
    tick();
    checkOutput("t6 reset an", {28'b0, an}, 32'hF);
    checkOutput("t6 reset sseg", {24'b0, sseg}, 32'hFF);
    checkOutput("t6 reset ftick", {31'b0, frame_tick}, 32'd0);
    reset = 1'b0;
    applyStimulus(16'h1234, 4'b0000, 1'b1);
    tick();
    checkOutput("t6 restart an", {28'b0, an}, 32'hE);
    checkOutput("t6 restart sseg", {24'b0, sseg}, 32'h03);
    repeat (4) tick();
    checkOutput("t6 restart d1 an", {28'b0, an}, 32'hD);
    checkOutput("t6 restart d1 sseg", {24'b0, sseg}, 32'hFF);
    blank_lz = 1'b0;
    waitFrameTick("t6");
    readFrame("t6 1234", 32'h9F250D99, 32'h9F250D99, 1'b0, 16'h0);

    repeat (2) tick();
    en = 1'b0;
    tick();
    checkOutput("t6 en0 an", {28'b0, an}, 32'hF);
    checkOutput("t6 en0 sseg", {24'b0, sseg}, 32'hFF);
    checkOutput("t6 en0 ftick", {31'b0, frame_tick}, 32'd0);
    repeat (5) tick();
    checkOutput("t6 en0 hold an", {28'b0, an}, 32'hF);
    checkOutput("t6 en0 hold sseg", {24'b0, sseg}, 32'hFF);
    en = 1'b1;
    tick();
    checkOutput("t6 resume an a", {28'b0, an}, 32'hE);
    checkOutput("t6 resume sseg a", {24'b0, sseg}, 32'h99);
    tick();
    checkOutput("t6 resume an b", {28'b0, an}, 32'hE);
    tick();
    checkOutput("t6 resume an c", {28'b0, an}, 32'hD);
    checkOutput("t6 resume sseg c", {24'b0, sseg}, 32'h0D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
